serial_key_matrix: RTL and testbench

Keyboard front end for the Galaksija core. It sits downstream of `uart_rx` and upstream of the Z80 memory-mapped keyboard window at 0x2000-0x27FF. Received ASCII bytes are queued in a FIFO, then translated to Galaksija matrix positions, including implicit SHIFT. Each key is held down long enough for the ROM scan loop to see it, then released with a gap, so pasted text types reliably. The block replaces the single-byte key latch in the top level and serves CPU reads of the 64-entry matrix.

---
 rtl/serial_key_matrix.sv | 146 ++++++++++++++
 tb/tb_serial_key_matrix.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_key_matrix.sv
// serial_key_matrix: queues received ASCII bytes and types them into the 64-entry
// Galaksija key matrix, holding each key for HOLD_CYCLES and releasing for GAP_CYCLES.
module serial_key_matrix #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int FIFO_AW     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       flush,
    input  logic       key_rd,
    input  logic [5:0] key_addr,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [63:0]        matrix;
    logic [31:0]        cnt, cnt_d;
    state_t             state, state_d;
    logic               pop, push, set_key, clr_key, mapped, shifted;
    logic [5:0]         idx;
    logic [7:0]         head;

    assign head      = mem[rd_ptr];
    assign push      = rx_valid && !flush && (count != DEPTH || pop);
    assign busy      = state != IDLE || count != 0;
    assign fifo_full = count == DEPTH;

    always_comb begin
        mapped  = 1'b1;
        shifted = 1'b0;
        idx     = 6'd0;
        if (head >= 8'h41 && head <= 8'h5A) idx = 6'(head - 8'h40);
        else if (head >= 8'h61 && head <= 8'h7A) idx = 6'(head - 8'h60);
        else if (head >= 8'h30 && head <= 8'h39) idx = 6'(head - 8'h10);
        else begin
            case (head)
                8'h0A, 8'h0D: idx = 6'd48;
                8'h08, 8'h7F: idx = 6'd29;
                8'h1B: idx = 6'd49;
                8'h20: idx = 6'd31;
                8'h3B: idx = 6'd42;
                8'h3A: idx = 6'd43;
                8'h2C: idx = 6'd44;
                8'h3D: idx = 6'd45;
                8'h2E: idx = 6'd46;
                8'h2F: idx = 6'd47;
                8'h5F: {shifted, idx} = {1'b1, 6'd32};
                8'h21: {shifted, idx} = {1'b1, 6'd33};
                8'h22: {shifted, idx} = {1'b1, 6'd34};
                8'h23: {shifted, idx} = {1'b1, 6'd35};
                8'h24: {shifted, idx} = {1'b1, 6'd36};
                8'h25: {shifted, idx} = {1'b1, 6'd37};
                8'h26: {shifted, idx} = {1'b1, 6'd38};
                8'h5C: {shifted, idx} = {1'b1, 6'd39};
                8'h28: {shifted, idx} = {1'b1, 6'd40};
                8'h29: {shifted, idx} = {1'b1, 6'd41};
                8'h2B: {shifted, idx} = {1'b1, 6'd42};
                8'h2A: {shifted, idx} = {1'b1, 6'd43};
                8'h3C: {shifted, idx} = {1'b1, 6'd44};
                8'h2D: {shifted, idx} = {1'b1, 6'd45};
                8'h3E: {shifted, idx} = {1'b1, 6'd46};
                8'h3F: {shifted, idx} = {1'b1, 6'd47};
                default: mapped = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        set_key = 1'b0;
        clr_key = 1'b0;
        case (state)
            IDLE: if (count != 0) begin
                pop = 1'b1;
                if (mapped) begin
                    set_key = 1'b1;
                    cnt_d   = 32'(HOLD_CYCLES - 1);
                    state_d = PRESS;
                end
            end
            PRESS: if (cnt == 0) begin
                clr_key = 1'b1;
                cnt_d   = 32'(GAP_CYCLES - 1);
                state_d = RELEASE;
            end else cnt_d = cnt - 1;
            RELEASE: if (cnt == 0) state_d = IDLE; else cnt_d = cnt - 1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= flush ? IDLE : state_d;
            cnt   <= flush ? '0 : cnt_d;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= rx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            if (rx_valid && !push) overflow <= 1'b1;
        end
    end

    // at most the primary key plus SHIFT (bit 53) are ever held together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) matrix <= '0;
        else if (flush || clr_key) matrix <= '0;
        else if (set_key) matrix <= (64'd1 << idx) | (shifted ? 64'd1 << 53 : 64'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) key_out <= 8'hFF;
        else if (key_rd) key_out <= matrix[key_addr] ? 8'hFE : 8'hFF;
    end
endmodule

// File: tb/tb_serial_key_matrix.sv
// tb_serial_key_matrix: directed checks of queueing, decode, hold/gap timing, overflow and flush.
module tb_serial_key_matrix;
    logic       clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, flush = 1'b0, key_rd = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [5:0] key_addr = 6'd1;
    logic [7:0] key_out;
    logic       busy, fifo_full, overflow;
    int         errors = 0, checks = 0;

    serial_key_matrix #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .flush(flush),
        .key_rd(key_rd), .key_addr(key_addr), .key_out(key_out), .busy(busy),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 60), 1);
    endtask

    initial begin
        #12;
        chk("rst_key_out", key_out, 8'hFF);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // reset asserted while 'A' is held
        key_addr = 6'd1;
        push("A");
        tick(); tick(); tick();
        chk("pre_rst_press", key_out, 8'hFE);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_key_out", key_out, 8'hFF);
        #2 reset = 1'b0;
        tick(); tick();
        chk("post_rst_addr1", key_out, 8'hFF);
        chk("post_rst_busy", busy, 0);

        // single key: 8-cycle press visible from E2, idle after E13
        push("a");
        for (int e = 1; e <= 14; e++) begin
            tick();
            chk($sformatf("single_key_e%0d", e), key_out, (e >= 2 && e <= 9) ? 8'hFE : 8'hFF);
            chk($sformatf("single_busy_e%0d", e), busy, 32'(e <= 12));
        end

        // shifted key sets SHIFT as well; key_out holds while key_rd is low
        key_addr = 6'd47;
        push("?");
        tick(); tick(); tick();
        chk("shift_addr47", key_out, 8'hFE);
        key_addr = 6'd53;
        tick();
        chk("shift_addr53", key_out, 8'hFE);
        key_rd = 1'b0;
        wait_idle();
        chk("hold_no_rd", key_out, 8'hFE);
        key_rd = 1'b1;
        key_addr = 6'd42;
        push(";");
        tick(); tick(); tick();
        chk("plain_addr42", key_out, 8'hFE);
        key_addr = 6'd53;
        tick();
        chk("plain_addr53", key_out, 8'hFF);
        wait_idle();

        // overflow: '1' popped, '2'-'5' fill, '6' dropped
        chk("pre_ovf", overflow, 0);
        for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
        chk("ovf_full", fifo_full, 1);
        chk("ovf_flag", overflow, 1);
        for (int e = 6; e <= 64; e++) begin
            key_addr = 6'(33 + (e - 2) / 13);
            tick();
            if ((e - 2) % 13 == 4) chk($sformatf("ovf_key%0d_on", 33 + (e - 2) / 13), key_out, 8'hFE);
            if ((e - 2) % 13 == 10) chk($sformatf("ovf_key%0d_off", 33 + (e - 2) / 13), key_out, 8'hFF);
        end
        key_addr = 6'd38;
        tick();
        chk("ovf_6_dropped_busy", busy, 0);
        chk("ovf_not_full", fifo_full, 0);
        chk("ovf_sticky", overflow, 1);

        // unmapped bytes are skipped one per cycle
        key_addr = 6'd2;
        push(8'h01);
        push(8'h80);
        push("B");
        tick();
        chk("unmap_e3", key_out, 8'hFF);
        tick();
        chk("unmap_e4", key_out, 8'hFE);
        key_addr = 6'd53;
        tick();
        chk("unmap_no_shift", key_out, 8'hFF);
        wait_idle();

        // flush while 'Z' is pressed with 3 bytes queued and 'C' arriving
        key_addr = 6'd26;
        push("Z");
        push("X");
        push("Y");
        push("W");
        tick();
        chk("flush_pre_press", key_out, 8'hFE);
        flush = 1'b1;
        rx_valid = 1'b1;
        rx_data = "C";
        tick();
        flush = 1'b0;
        rx_valid = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_full", fifo_full, 0);
        tick();
        chk("flush_addr26", key_out, 8'hFF);
        key_addr = 6'd3;
        for (int e = 0; e < 16; e++) begin
            tick();
            chk("flush_no_c", key_out, 8'hFF);
        end
        chk("flush_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
